dbus_arbiter: RTL and testbench
===============================

# dbus_arbiter

Two-master arbiter sharing one generic bus data port between the pipeline memory stage (port 0) and a secondary requester (port 1), such as a debug module or RISC-MGMT extension. It sits between the memory-stage data port and the downstream data cache or memory bus. It grants one master at a time and holds the grant for a full transaction. Fairness is round-robin, or fixed priority when round-robin is compiled out.

## Interface
- No parameters; address and data widths are the codebase `WORD_SIZE` (32).
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- m0_ren, m0_wen  in  1 each  port 0 read/write request (memory stage)
- m0_addr, m0_wdata  in  32 each  port 0 address / write data
- m0_byte_en  in  4  port 0 byte enables
- m0_rdata  out  32  port 0 read data
- m0_busy  out  1  port 0 busy; 0 means the transaction completed this cycle
- m0_error  out  1  port 0 bus error, valid when m0_busy=0
- m1_*  same set as m0_*  port 1 (secondary requester)
- s_ren, s_wen  out  1 each  downstream read/write request
- s_addr, s_wdata  out  32 each  downstream address / write data
- s_byte_en  out  4  downstream byte enables
- s_rdata  in  32  downstream read data
- s_busy  in  1  downstream busy
- s_error  in  1  downstream error
- grant  out  2  one-hot current owner: 01 = port 0, 10 = port 1, 00 = idle (debug/perf)

## Operation
- A port requests when `ren | wen` is high. Requesters hold ren/wen, addr, wdata and byte_en stable until they see busy=0.
- FSM states:
  - IDLE: no owner.
  - OWN0: port 0 owns the bus.
  - OWN1: port 1 owns the bus.
- IDLE transitions:
  - Only one port requesting: go to that port's OWN state.
  - Both requesting: go to the OWN state selected by the priority pointer `prio` (0 or 1).
  - No request: stay in IDLE.
- OWNx behaviour:
  - Port x signals pass through to the s_* outputs.
  - s_rdata and s_error go to mx_rdata and mx_error.
  - mx_busy follows s_busy.
- OWNx completion: when s_busy=0 while port x's request is high, the transaction completes.
  - mx_busy=0 that cycle.
  - Next state is IDLE.
  - With round-robin, `prio` is set to the other port.
- Abort: if port x drops ren and wen while in OWNx, go to IDLE next cycle with no `prio` update. s_ren/s_wen follow port x combinationally, so they are already 0 that cycle.
- Non-owner port: busy=1, rdata=0, error=0.
- IDLE outputs:
  - s_ren = s_wen = 0; s_addr, s_wdata and s_byte_en = 0.
  - Both busy outputs equal 1 while the corresponding port requests, otherwise 0.
- ren and wen high together: forwarded unchanged. Legality is the requester's responsibility.
- s_error with s_busy=0 completes the transaction exactly like a normal completion.

## Timing
- Reset values: state=IDLE, prio=0, grant=00, s_ren=s_wen=0, s_addr=s_wdata=0, s_byte_en=0, m0_rdata=m1_rdata=0, m0_error=m1_error=0.
- Reset busy outputs: both m0_busy and m1_busy = 1 while the corresponding port requests, otherwise 0, as in IDLE.
- Arbitration latency is 1 cycle:
  - A request first seen in IDLE at cycle N drives the downstream request at N+1.
  - mx_busy=1 at cycle N.
- Back-to-back: after completion at cycle N, the arbiter is in IDLE at N+1. A waiting request is granted for N+2.
- This gives one dead cycle between transactions; minimum per-transaction occupancy is 2 cycles.
- Reset mid-transaction:
  - State is IDLE on the next edge; downstream request drops in that same cycle.
  - The requester still sees busy=1 and must retry.
- Busy outputs are combinational from state, requests and s_busy. All other state is registered.

## Configuration
- `DBUS_ARB_RR_EN` defined: round-robin. `prio` toggles to the other port after each completed transaction.
- `DBUS_ARB_RR_EN` undefined: fixed priority. `prio` is held at 0, so port 0 always wins a tie. Port 1 is served only when port 0 is not requesting in IDLE.

## Test plan
- Single read:
  - Stimulus: m0_ren=1, addr=0x100; downstream s_busy=1 for 2 cycles, then 0 with s_rdata=0xDEADBEEF.
  - Required: s_ren high from cycle 1; m0_busy=0 with m0_rdata=0xDEADBEEF in cycle 3; grant=00 in cycle 4.
- Tie, round-robin:
  - Stimulus: m0 and m1 both request at cycle 0; each transaction takes 1 busy cycle.
  - Required: port 0 served first; port 1 granted at cycle 4; afterwards prio=0.
- Tie, fixed priority (macro undefined):
  - Stimulus: m0 requests continuously; m1 requests.
  - Required: m1_busy stays 1 and grant never equals 10.
- Abort:
  - Stimulus: m1 owns the bus; m1_wen drops mid-transaction.
  - Required: s_wen=0 the same cycle; IDLE next cycle; prio unchanged.
- Error:
  - Stimulus: s_error=1 with s_busy=0 during OWN0.
  - Required: m0_error=1 and m0_busy=0 that cycle; m1_error stays 0.
- Reset mid-transaction:
  - Stimulus: RST=1 while in OWN1.
  - Required: next cycle grant=00, s_ren=s_wen=0, prio=0.

Source files
------------

// File: rtl/dbus_arbiter_if.sv
// Generic data-bus port bundle shared by the requesters and the downstream side of dbus_arbiter.
// A master drives the request fields; a slave answers with read data, busy and error.
interface dbus_arbiter_if;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [31:0] rdata;
    logic        busy;
    logic        error;

    modport master (output ren, wen, addr, wdata, byte_en, input  rdata, busy, error);
    modport slave  (input  ren, wen, addr, wdata, byte_en, output rdata, busy, error);
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: memory stage (m0) and secondary requester (m1) share one downstream port.
// Define DBUS_ARB_RR_EN for round-robin fairness; otherwise port 0 has fixed priority on ties.
module dbus_arbiter (
    input  logic                  CLK,
    input  logic                  RST,
    dbus_arbiter_if.slave         m0,
    dbus_arbiter_if.slave         m1,
    dbus_arbiter_if.master        s,
    output logic [1:0]            grant
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d, out_state_s;
    logic   prio_q, prio_d;
    logic   m0_req_s, m1_req_s;

    assign m0_req_s = m0.ren | m0.wen;
    assign m1_req_s = m1.ren | m1.wen;

    // Next owner and priority pointer; a dropped request releases the bus without touching prio.
    always_comb begin
        state_d = state_q;
`ifdef DBUS_ARB_RR_EN
        prio_d  = prio_q;
`else
        prio_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req_s && m1_req_s) begin
                    state_d = prio_q ? OWN1 : OWN0;
                end else if (m0_req_s) begin
                    state_d = OWN0;
                end else if (m1_req_s) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0: begin
                if (!m0_req_s) begin
                    state_d = IDLE;
                end else if (!s.busy) begin
                    state_d = IDLE;
`ifdef DBUS_ARB_RR_EN
                    prio_d  = 1'b1;
`endif
                end else begin
                    state_d = OWN0;
                end
            end
            OWN1: begin
                if (!m1_req_s) begin
                    state_d = IDLE;
                end else if (!s.busy) begin
                    state_d = IDLE;
`ifdef DBUS_ARB_RR_EN
                    prio_d  = 1'b0;
`endif
                end else begin
                    state_d = OWN1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Owner and priority registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Bus steering; reset presents the idle view so the downstream request drops immediately.
    always_comb begin
        out_state_s = RST ? IDLE : state_q;
        s.ren       = 1'b0;
        s.wen       = 1'b0;
        s.addr      = 32'h0000_0000;
        s.wdata     = 32'h0000_0000;
        s.byte_en   = 4'h0;
        m0.rdata    = 32'h0000_0000;
        m0.error    = 1'b0;
        m0.busy     = m0_req_s;
        m1.rdata    = 32'h0000_0000;
        m1.error    = 1'b0;
        m1.busy     = m1_req_s;
        grant       = 2'b00;
        case (out_state_s)
            OWN0: begin
                s.ren     = m0.ren;
                s.wen     = m0.wen;
                s.addr    = m0.addr;
                s.wdata   = m0.wdata;
                s.byte_en = m0.byte_en;
                m0.rdata  = s.rdata;
                m0.error  = s.error;
                m0.busy   = s.busy;
                m1.busy   = 1'b1;
                grant     = 2'b01;
            end
            OWN1: begin
                s.ren     = m1.ren;
                s.wen     = m1.wen;
                s.addr    = m1.addr;
                s.wdata   = m1.wdata;
                s.byte_en = m1.byte_en;
                m1.rdata  = s.rdata;
                m1.error  = s.error;
                m1.busy   = s.busy;
                m0.busy   = 1'b1;
                grant     = 2'b10;
            end
            default: begin
                grant     = 2'b00;
            end
        endcase
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against an owner/priority reference model.
module tb_dbus_arbiter;
    logic        CLK;
    logic        b_rst;
    logic        b_ren   [2];
    logic        b_wen   [2];
    logic [31:0] b_addr  [2];
    logic [31:0] b_wdata [2];
    logic [3:0]  b_be    [2];
    logic        b_sbusy;
    logic        b_serror;
    logic [31:0] b_srdata;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;
    int owner    = 0;   // 0 = nobody, 1 = port 0, 2 = port 1
    bit prio     = 1'b0;

    dbus_arbiter_if m0_if ();
    dbus_arbiter_if m1_if ();
    dbus_arbiter_if s_if ();

    assign m0_if.ren = b_ren[0];   assign m1_if.ren = b_ren[1];
    assign m0_if.wen = b_wen[0];   assign m1_if.wen = b_wen[1];
    assign m0_if.addr = b_addr[0]; assign m1_if.addr = b_addr[1];
    assign m0_if.wdata = b_wdata[0]; assign m1_if.wdata = b_wdata[1];
    assign m0_if.byte_en = b_be[0];  assign m1_if.byte_en = b_be[1];
    assign s_if.busy  = b_sbusy;
    assign s_if.error = b_serror;
    assign s_if.rdata = b_srdata;

    dbus_arbiter dut (
        .CLK   (CLK),
        .RST   (b_rst),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .grant (grant)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        b_ren[p] = r; b_wen[p] = w; b_addr[p] = a; b_wdata[p] = d; b_be[p] = be;
    endtask

    // Compare every DUT output with what the current owner implies.
    task automatic check_all();
        int eo;
        int k;
        logic exp_busy [2];
        logic [31:0] exp_rdata [2];
        logic exp_err [2];
        eo = b_rst ? 0 : owner;
        for (int p = 0; p < 2; p++) begin
            if (eo == 0)          exp_busy[p] = b_ren[p] | b_wen[p];
            else if (eo == p + 1) exp_busy[p] = b_sbusy;
            else                  exp_busy[p] = 1'b1;
            exp_rdata[p] = (eo == p + 1) ? b_srdata : 32'h0;
            exp_err[p]   = (eo == p + 1) ? b_serror : 1'b0;
        end
        k = (eo == 0) ? 0 : eo - 1;
        chk("grant",    {30'd0, grant}, (eo == 1) ? 32'd1 : (eo == 2) ? 32'd2 : 32'd0);
        chk("s_ren",    {31'd0, s_if.ren},   (eo == 0) ? 32'd0 : {31'd0, b_ren[k]});
        chk("s_wen",    {31'd0, s_if.wen},   (eo == 0) ? 32'd0 : {31'd0, b_wen[k]});
        chk("s_addr",   s_if.addr,           (eo == 0) ? 32'd0 : b_addr[k]);
        chk("s_wdata",  s_if.wdata,          (eo == 0) ? 32'd0 : b_wdata[k]);
        chk("s_byte_en",{28'd0, s_if.byte_en}, (eo == 0) ? 32'd0 : {28'd0, b_be[k]});
        chk("m0_busy",  {31'd0, m0_if.busy},  {31'd0, exp_busy[0]});
        chk("m1_busy",  {31'd0, m1_if.busy},  {31'd0, exp_busy[1]});
        chk("m0_rdata", m0_if.rdata, exp_rdata[0]);
        chk("m1_rdata", m1_if.rdata, exp_rdata[1]);
        chk("m0_error", {31'd0, m0_if.error}, {31'd0, exp_err[0]});
        chk("m1_error", {31'd0, m1_if.error}, {31'd0, exp_err[1]});
    endtask

    // Reference rules: idle picks the sole requester or prio on a tie; owner leaves on drop or completion.
    task automatic model_next();
        bit r0, r1;
        int k;
        r0 = b_ren[0] | b_wen[0];
        r1 = b_ren[1] | b_wen[1];
        if (b_rst) begin
            owner = 0;
            prio  = 1'b0;
        end else if (owner == 0) begin
            if (r0 && r1)  owner = prio ? 2 : 1;
            else if (r0)   owner = 1;
            else if (r1)   owner = 2;
        end else begin
            k = owner - 1;
            if (!(b_ren[k] | b_wen[k])) begin
                owner = 0;
            end else if (!b_sbusy) begin
                owner = 0;
`ifdef DBUS_ARB_RR_EN
                prio = (k == 0);
`endif
            end
        end
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic adv();
        @(posedge CLK);
        model_next();
        @(negedge CLK);
    endtask

    initial begin
        logic        n_ren [2];
        logic        n_wen [2];
        logic [31:0] n_addr [2];
        logic [31:0] n_wdata [2];
        logic [3:0]  n_be [2];
        logic [1:0]  rw;
        logic        obs_busy;

        b_rst = 1'b1; b_sbusy = 1'b1; b_serror = 1'b0; b_srdata = 32'h0;
        for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge CLK);
        settle(); adv(); settle(); adv();
        b_rst = 1'b0;

        // Single read with two busy cycles.
        set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        settle(); chk("rd_c0_grant", {30'd0, grant}, 32'd0); chk("rd_c0_busy", {31'd0, m0_if.busy}, 32'd1); adv();
        settle(); chk("rd_c1_sren", {31'd0, s_if.ren}, 32'd1); adv();
        settle(); adv();
        b_sbusy = 1'b0; b_srdata = 32'hDEADBEEF;
        settle(); chk("rd_c3_rdata", m0_if.rdata, 32'hDEADBEEF); chk("rd_c3_busy", {31'd0, m0_if.busy}, 32'd0); adv();
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); b_sbusy = 1'b1;
        settle(); chk("rd_c4_grant", {30'd0, grant}, 32'd0); adv();

        // Tie: port 0 first, port 1 at cycle 4, then prio back at port 0.
        set_port(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        set_port(1, 1'b1, 1'b0, 32'h300, 32'h0, 4'h3);
        settle(); adv();
        settle(); chk("tie_c1_grant", {30'd0, grant}, 32'd1); adv();
        b_sbusy = 1'b0; settle(); adv();
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); b_sbusy = 1'b1;
        settle(); adv();
        settle(); chk("tie_c4_grant", {30'd0, grant}, 32'd2); adv();
        b_sbusy = 1'b0; settle(); adv();
        set_port(0, 1'b1, 1'b0, 32'h204, 32'h0, 4'hF); b_sbusy = 1'b1;
        settle(); adv();
        settle(); chk("tie_after_grant", {30'd0, grant}, 32'd1); adv();
        b_sbusy = 1'b0; settle(); adv();

        // Port 0 requesting continuously against port 1.
        for (int i = 0; i < 12; i++) begin
            b_sbusy = i[0];
            settle();
`ifndef DBUS_ARB_RR_EN
            chk("fp_m1_busy", {31'd0, m1_if.busy}, 32'd1);
            chk("fp_no_grant1", {31'd0, grant == 2'b10}, 32'd0);
`endif
            adv();
        end
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        b_sbusy = 1'b1;
        settle(); adv(); settle(); adv();

        // Abort: port 1 drops its write while owning the bus.
        set_port(1, 1'b0, 1'b1, 32'h400, 32'h1234_5678, 4'hC);
        settle(); adv();
        settle(); chk("ab_c1_swen", {31'd0, s_if.wen}, 32'd1); adv();
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle(); chk("ab_c2_swen", {31'd0, s_if.wen}, 32'd0); adv();
        settle(); chk("ab_c3_grant", {30'd0, grant}, 32'd0); adv();

        // Error completion on port 0.
        set_port(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
        settle(); adv(); settle(); adv();
        b_sbusy = 1'b0; b_serror = 1'b1;
        settle();
        chk("err_m0_error", {31'd0, m0_if.error}, 32'd1);
        chk("err_m0_busy", {31'd0, m0_if.busy}, 32'd0);
        chk("err_m1_error", {31'd0, m1_if.error}, 32'd0);
        adv();
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); b_serror = 1'b0; b_sbusy = 1'b1;
        settle(); adv();

        // Reset while port 1 owns the bus; a tie afterwards must go to port 0.
        set_port(1, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
        settle(); adv();
        settle(); chk("rst_c1_grant", {30'd0, grant}, 32'd2); adv();
        b_rst = 1'b1; settle(); chk("rst_c2_sren", {31'd0, s_if.ren}, 32'd0); adv();
        b_rst = 1'b0; set_port(0, 1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
        settle();
        chk("rst_c3_grant", {30'd0, grant}, 32'd0);
        chk("rst_c3_sren", {31'd0, s_if.ren}, 32'd0);
        chk("rst_c3_m1busy", {31'd0, m1_if.busy}, 32'd1);
        adv();
        settle(); chk("rst_c4_grant", {30'd0, grant}, 32'd1); adv();
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle(); adv();

        // Randomized traffic: requesters hold until busy=0, occasionally abort; rare resets.
        for (int i = 0; i < 600; i++) begin
            b_sbusy  = ($urandom_range(0, 2) != 0);
            b_serror = ($urandom_range(0, 7) == 0);
            b_srdata = $urandom;
            b_rst    = ($urandom_range(0, 59) == 0);
            settle();
            for (int p = 0; p < 2; p++) begin
                n_ren[p] = b_ren[p]; n_wen[p] = b_wen[p]; n_addr[p] = b_addr[p];
                n_wdata[p] = b_wdata[p]; n_be[p] = b_be[p];
                obs_busy = (p == 0) ? m0_if.busy : m1_if.busy;
                if (!(b_ren[p] | b_wen[p]) || !obs_busy) begin
                    if ($urandom_range(0, 1) == 0) begin
                        rw = 2'($urandom_range(1, 3));
                        n_ren[p] = rw[0]; n_wen[p] = rw[1];
                        n_addr[p] = $urandom; n_wdata[p] = $urandom; n_be[p] = 4'($urandom);
                    end else begin
                        n_ren[p] = 1'b0; n_wen[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 29) == 0) begin
                    n_ren[p] = 1'b0; n_wen[p] = 1'b0;
                end
            end
            adv();
            for (int p = 0; p < 2; p++) set_port(p, n_ren[p], n_wen[p], n_addr[p], n_wdata[p], n_be[p]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
